// File: rtl/pc_fetch_ras_if.sv
// Control and status bundle between the fetch controller and the PC/return-stack unit.
// The master drives the branch controls; the slave (pc_fetch_ras) returns the PC and stack state.
interface pc_fetch_ras_if #(
  parameter int PC_W      = 16,
  parameter int COND_W    = 8,
  parameter int UNCOND_W  = 11,
  parameter int LINK_W    = 6,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic                stall;
  logic                br_taken;
  logic [1:0]          branch_type;
  logic                reg_branch;
  logic [COND_W-1:0]   cond_offset;
  logic [UNCOND_W-1:0] uncond_offset;
  logic [LINK_W-1:0]   link_offset;
  logic [PC_W-1:0]     reg_target;
  logic                ret;

  logic [PC_W-1:0]     pc;
  logic [PC_W-1:0]     link_pc;
  logic [PC_W-1:0]     ras_top;
  logic [CNT_W-1:0]    ras_count;
  logic                ras_empty;
  logic                ras_full;
  logic                ras_overflow;

  modport master (
    output stall, br_taken, branch_type, reg_branch, cond_offset,
           uncond_offset, link_offset, reg_target, ret,
    input  pc, link_pc, ras_top, ras_count, ras_empty, ras_full, ras_overflow
  );

  modport slave (
    input  stall, br_taken, branch_type, reg_branch, cond_offset,
           uncond_offset, link_offset, reg_target, ret,
    output pc, link_pc, ras_top, ras_count, ras_empty, ras_full, ras_overflow
  );
endinterface

// File: rtl/pc_fetch_ras.sv
// Registered program counter with next-PC selection and a circular hardware return-address stack.
// Calls push pc+1; returns pop it, falling back to reg_target when the stack is empty.
module pc_fetch_ras #(
  parameter int              PC_W      = 16,
  parameter int              COND_W    = 8,
  parameter int              UNCOND_W  = 11,
  parameter int              LINK_W    = 6,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic          clk,
  input  logic          reset,
  pc_fetch_ras_if.slave bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    BR_COND   = 2'b00,
    BR_UNCOND = 2'b01,
    BR_LINK   = 2'b10,
    BR_REG    = 2'b11
  } br_type_e;

  logic [PC_W-1:0]  pc_q, pc_d, link_pc, ras_top;
  logic [PC_W-1:0]  cond_sext, uncond_sext, link_sext;
  logic [PTR_W-1:0] sp_q, top_idx;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             ras_empty, ras_full, do_push, do_pop;
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];

  assign cond_sext   = {{(PC_W-COND_W){bus.cond_offset[COND_W-1]}}, bus.cond_offset};
  assign uncond_sext = {{(PC_W-UNCOND_W){bus.uncond_offset[UNCOND_W-1]}}, bus.uncond_offset};
  assign link_sext   = {{(PC_W-LINK_W){bus.link_offset[LINK_W-1]}}, bus.link_offset};

  // sp_q is the next free slot; the newest entry sits one below it, modulo depth.
  assign top_idx   = sp_q - PTR_W'(1);
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == CNT_W'(RAS_DEPTH));
  assign ras_top   = ras_empty ? '0 : ras_mem[top_idx];
  assign link_pc   = pc_q + PC_W'(1);

  assign do_pop  = !bus.stall && bus.ret && !ras_empty;
  assign do_push = !bus.stall && !bus.ret && bus.br_taken && !bus.reg_branch &&
                   (br_type_e'(bus.branch_type) == BR_LINK);

  always_comb begin
    // NOTE: pc_d gets a default before any branch so no path leaves it unassigned (no latch).
    pc_d = link_pc;
    if (bus.ret) begin
      pc_d = ras_empty ? bus.reg_target : ras_top;
    end else if (bus.br_taken) begin
      if (bus.reg_branch) begin
        pc_d = bus.reg_target;
      end else begin
        case (br_type_e'(bus.branch_type))
          BR_COND:   pc_d = pc_q + cond_sext;
          BR_UNCOND: pc_d = pc_q + uncond_sext;
          BR_LINK:   pc_d = pc_q + link_sext;
          default:   pc_d = bus.reg_target;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      pc_q    <= RESET_PC;
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (!bus.stall) begin
      pc_q <= pc_d;
      if (do_push) begin
        sp_q <= sp_q + PTR_W'(1);
        if (ras_full) ovf_q   <= 1'b1;
        else          count_q <= count_q + CNT_W'(1);
      end else if (do_pop) begin
        sp_q    <= top_idx;
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // NOTE: stack storage is not reset; entries are only read while count_q marks them valid.
  always_ff @(posedge clk) begin
    if (!reset && do_push) ras_mem[sp_q] <= link_pc;
  end

  assign bus.pc           = pc_q;
  assign bus.link_pc      = link_pc;
  assign bus.ras_top      = ras_top;
  assign bus.ras_count    = count_q;
  assign bus.ras_empty    = ras_empty;
  assign bus.ras_full     = ras_full;
  assign bus.ras_overflow = ovf_q;
endmodule

// File: tb/tb_pc_fetch_ras.sv
// Directed bench for pc_fetch_ras: a table of per-cycle vectors with hand-computed PC/stack state,
// followed by hand-written offset-boundary and multi-cycle stall sequences.
module tb_pc_fetch_ras;
  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  pc_fetch_ras_if bus ();

  pc_fetch_ras dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        rst, stall, br, rb, ret;
    logic [1:0]  bt;
    logic [15:0] off, rt;
    logic [15:0] e_pc, e_top;
    int          e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t vec(string name, logic rst, logic stall, logic br, logic [1:0] bt,
                               logic rb, logic [15:0] off, logic [15:0] rt, logic ret,
                               logic [15:0] e_pc, logic [15:0] e_top, int e_cnt, logic e_ovf);
    vec_t v;
    v.name = name; v.rst = rst; v.stall = stall; v.br = br; v.bt = bt; v.rb = rb;
    v.off = off; v.rt = rt; v.ret = ret;
    v.e_pc = e_pc; v.e_top = e_top; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic check(string name, string what, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %h want %h", name, what, act, exp);
    end
  endtask

  // The shared offset value feeds all three offset fields; only the selected one may matter.
  task automatic apply(vec_t v);
    logic [15:0] exp_link;
    reset             = v.rst;
    bus.stall         = v.stall;
    bus.br_taken      = v.br;
    bus.branch_type   = v.bt;
    bus.reg_branch    = v.rb;
    bus.cond_offset   = v.off[7:0];
    bus.uncond_offset = v.off[10:0];
    bus.link_offset   = v.off[5:0];
    bus.reg_target    = v.rt;
    bus.ret           = v.ret;
    @(posedge clk);
    #1;
    exp_link = v.e_pc + 16'd1;
    check(v.name, "pc",       32'(bus.pc),           32'(v.e_pc));
    check(v.name, "link_pc",  32'(bus.link_pc),      32'(exp_link));
    check(v.name, "ras_top",  32'(bus.ras_top),      32'(v.e_top));
    check(v.name, "count",    32'(bus.ras_count),    32'(v.e_cnt));
    check(v.name, "empty",    32'(bus.ras_empty),    32'(v.e_cnt == 0));
    check(v.name, "full",     32'(bus.ras_full),     32'(v.e_cnt == 4));
    check(v.name, "overflow", 32'(bus.ras_overflow), 32'(v.e_ovf));
  endtask

  initial begin
    //                 name        rst stl br  bt    rb  off       rt        ret   pc        top       cnt ovf
    vecs.push_back(vec("rst",       1, 0, 0, 2'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(vec("idle1",     0, 0, 0, 2'd0, 0, 16'h0000, 16'h0000, 0, 16'h0001, 16'h0000, 0, 0));
    vecs.push_back(vec("idle2",     0, 0, 0, 2'd0, 0, 16'h0000, 16'h0000, 0, 16'h0002, 16'h0000, 0, 0));
    vecs.push_back(vec("idle3",     0, 0, 0, 2'd0, 0, 16'h0000, 16'h0000, 0, 16'h0003, 16'h0000, 0, 0));
    vecs.push_back(vec("idle4",     0, 0, 0, 2'd0, 0, 16'h0000, 16'h0000, 0, 16'h0004, 16'h0000, 0, 0));
    vecs.push_back(vec("nolink",    0, 0, 0, 2'd2, 0, 16'h0005, 16'h0000, 0, 16'h0005, 16'h0000, 0, 0));
    vecs.push_back(vec("j_ffff",    0, 0, 1, 2'd3, 0, 16'h0000, 16'hFFFF, 0, 16'hFFFF, 16'h0000, 0, 0));
    vecs.push_back(vec("wrap",      0, 0, 0, 2'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(vec("j_0010",    0, 0, 1, 2'd0, 1, 16'h0022, 16'h0010, 0, 16'h0010, 16'h0000, 0, 0));
    vecs.push_back(vec("cond_neg",  0, 0, 1, 2'd0, 0, 16'h00F8, 16'h0000, 0, 16'h0008, 16'h0000, 0, 0));
    vecs.push_back(vec("uncond",    0, 0, 1, 2'd1, 0, 16'h0100, 16'h0000, 0, 16'h0108, 16'h0000, 0, 0));
    vecs.push_back(vec("rb_beef",   0, 0, 1, 2'd1, 1, 16'h0100, 16'hBEEF, 0, 16'hBEEF, 16'h0000, 0, 0));
    vecs.push_back(vec("j_0020",    0, 0, 1, 2'd3, 0, 16'h0000, 16'h0020, 0, 16'h0020, 16'h0000, 0, 0));
    vecs.push_back(vec("call",      0, 0, 1, 2'd2, 0, 16'h0005, 16'h0000, 0, 16'h0025, 16'h0021, 1, 0));
    vecs.push_back(vec("ret",       0, 0, 0, 2'd0, 0, 16'h0000, 16'h0000, 1, 16'h0021, 16'h0000, 0, 0));
    vecs.push_back(vec("ret_empty", 0, 0, 0, 2'd0, 0, 16'h0000, 16'h0777, 1, 16'h0777, 16'h0000, 0, 0));
    vecs.push_back(vec("call_a",    0, 0, 1, 2'd2, 0, 16'h0010, 16'h0000, 0, 16'h0787, 16'h0778, 1, 0));
    vecs.push_back(vec("call_b",    0, 0, 1, 2'd2, 0, 16'h0010, 16'h0000, 0, 16'h0797, 16'h0788, 2, 0));
    vecs.push_back(vec("call_c",    0, 0, 1, 2'd2, 0, 16'h0010, 16'h0000, 0, 16'h07A7, 16'h0798, 3, 0));
    vecs.push_back(vec("call_d",    0, 0, 1, 2'd2, 0, 16'h0010, 16'h0000, 0, 16'h07B7, 16'h07A8, 4, 0));
    vecs.push_back(vec("call_e",    0, 0, 1, 2'd2, 0, 16'h0010, 16'h0000, 0, 16'h07C7, 16'h07B8, 4, 1));
    vecs.push_back(vec("ret_1",     0, 0, 0, 2'd0, 0, 16'h0000, 16'h0000, 1, 16'h07B8, 16'h07A8, 3, 1));
    vecs.push_back(vec("ret_2",     0, 0, 0, 2'd0, 0, 16'h0000, 16'h0000, 1, 16'h07A8, 16'h0798, 2, 1));
    vecs.push_back(vec("ret_3",     0, 0, 0, 2'd0, 0, 16'h0000, 16'h0000, 1, 16'h0798, 16'h0788, 1, 1));
    vecs.push_back(vec("ret_4",     0, 0, 0, 2'd0, 0, 16'h0000, 16'h0000, 1, 16'h0788, 16'h0000, 0, 1));
    vecs.push_back(vec("ret_5",     0, 0, 0, 2'd0, 0, 16'h0000, 16'h1234, 1, 16'h1234, 16'h0000, 0, 1));
    vecs.push_back(vec("call_neg",  0, 0, 1, 2'd2, 0, 16'h003C, 16'h0000, 0, 16'h1230, 16'h1235, 1, 1));
    vecs.push_back(vec("ret_call",  0, 0, 1, 2'd2, 0, 16'h0005, 16'h0000, 1, 16'h1235, 16'h0000, 0, 1));
    vecs.push_back(vec("call2",     0, 0, 1, 2'd2, 0, 16'h0002, 16'h0000, 0, 16'h1237, 16'h1236, 1, 1));
    vecs.push_back(vec("stl_ret",   0, 1, 0, 2'd0, 0, 16'h0000, 16'h0000, 1, 16'h1237, 16'h1236, 1, 1));
    vecs.push_back(vec("stl_call",  0, 1, 1, 2'd2, 0, 16'h0005, 16'h0000, 0, 16'h1237, 16'h1236, 1, 1));
    vecs.push_back(vec("stl_jmp",   0, 1, 1, 2'd3, 0, 16'h0000, 16'hAAAA, 0, 16'h1237, 16'h1236, 1, 1));
    vecs.push_back(vec("go",        0, 0, 0, 2'd0, 0, 16'h0000, 16'h0000, 0, 16'h1238, 16'h1236, 1, 1));
    vecs.push_back(vec("call3",     0, 0, 1, 2'd2, 0, 16'h0001, 16'h0000, 0, 16'h1239, 16'h1239, 2, 1));
    vecs.push_back(vec("call4",     0, 0, 1, 2'd2, 0, 16'h0001, 16'h0000, 0, 16'h123A, 16'h123A, 3, 1));
    vecs.push_back(vec("rst_call",  1, 0, 1, 2'd2, 0, 16'h0001, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(vec("idle5",     0, 0, 0, 2'd0, 0, 16'h0000, 16'h0000, 0, 16'h0001, 16'h0000, 0, 0));
    vecs.push_back(vec("rst_stl",   1, 1, 0, 2'd0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // Offset extremes and modulo wrap around the top of the address space.
    apply(vec("j_ffff2",  0, 0, 1, 2'd3, 0, 16'h0000, 16'hFFFF, 0, 16'hFFFF, 16'h0000, 0, 0));
    apply(vec("cond_max", 0, 0, 1, 2'd0, 0, 16'h007F, 16'h0000, 0, 16'h007E, 16'h0000, 0, 0));
    apply(vec("cond_min", 0, 0, 1, 2'd0, 0, 16'h0080, 16'h0000, 0, 16'hFFFE, 16'h0000, 0, 0));
    apply(vec("unc_min",  0, 0, 1, 2'd1, 0, 16'h0400, 16'h0000, 0, 16'hFBFE, 16'h0000, 0, 0));
    apply(vec("call_max", 0, 0, 1, 2'd2, 0, 16'h001F, 16'h0000, 0, 16'hFC1D, 16'hFBFF, 1, 0));

    // Several stalled cycles with mixed ret/branch requests: all state must hold.
    for (int k = 0; k < 5; k++) begin
      logic       r_ret, r_br;
      logic [1:0] r_bt;
      r_ret = 1'($urandom_range(0, 1));
      r_br  = 1'($urandom_range(0, 1));
      r_bt  = 2'($urandom_range(0, 3));
      apply(vec($sformatf("stall_%0d", k), 0, 1, r_br, r_bt, 0, 16'h0011, 16'h5555, r_ret,
                16'hFC1D, 16'hFBFF, 1, 0));
    end
    apply(vec("ret_go",   0, 0, 0, 2'd0, 0, 16'h0000, 16'h0000, 1, 16'hFBFF, 16'h0000, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_fetch_ras.md
Name: pc_fetch_ras

Overview:
Registered program-counter unit with a hardware return-address stack (RAS). It is the parametrised successor to the combinational next-PC logic and owns the PC register itself. Each cycle it selects the next PC from one of these sources: sequential PC+1, PC-relative conditional, unconditional or link branch, an absolute register target, or a RAS-predicted return. It sits at the front of the single-cycle datapath and drives the instruction-memory address.

Parameters:
PC_W, 16, PC and address width
COND_W, 8, conditional-branch offset width (signed)
UNCOND_W, 11, unconditional-branch offset width (signed)
LINK_W, 6, link-branch offset width (signed)
RAS_DEPTH, 4, return-stack entries (power of 2, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
stall  in  1  hold PC and RAS this cycle
br_taken  in  1  branch resolved taken
branch_type  in  2  00 cond, 01 uncond, 10 link (call), 11 register
reg_branch  in  1  force absolute register target when br_taken
cond_offset  in  COND_W  signed PC-relative offset
uncond_offset  in  UNCOND_W  signed PC-relative offset
link_offset  in  LINK_W  signed PC-relative offset
reg_target  in  PC_W  register-file data used as absolute target
ret  in  1  return instruction; pop RAS
pc  out  PC_W  current PC (registered)
link_pc  out  PC_W  pc+1, combinational
ras_top  out  PC_W  top RAS entry (0 when empty)
ras_count  out  clog2(RAS_DEPTH)+1  valid entries
ras_empty  out  1  ras_count==0
ras_full  out  1  ras_count==RAS_DEPTH
ras_overflow  out  1  sticky: a push overwrote the oldest entry

Behaviour:
- Reset (synchronous, has priority over everything, including mid-call or mid-stall):
  - pc=RESET_PC, ras_count=0, stack pointer=0, ras_overflow=0.
  - Stack contents are don't-care; ras_top reads 0 while empty.
- Arithmetic: offsets are sign-extended to PC_W; target = pc + sext(offset), modulo 2^PC_W. The offset is added to the current pc, not to pc+1. link_pc = pc+1, also modulo 2^PC_W (0xFFFF -> 0x0000).
- Next-PC priority, evaluated each cycle when stall=0:
  1. ret=1 and RAS not empty: pc <= ras_top; pop (count-1). br_taken is ignored and no push happens.
  2. ret=1 and RAS empty: pc <= reg_target (software link-register fallback); no stack change.
  3. br_taken=1 and (reg_branch=1 or branch_type=11): pc <= reg_target.
  4. br_taken=1, branch_type=00/01/10: pc <= pc + sext of cond_offset/uncond_offset/link_offset respectively.
  5. Otherwise: pc <= pc+1.
- Push rule: a push happens when br_taken=1, branch_type=10, reg_branch=0, ret=0 and stall=0. The value pushed is link_pc.
  - Not full: write at pointer, pointer+1, count+1.
  - Full: circular overwrite of the oldest entry; pointer advances, count stays RAS_DEPTH, ras_overflow <= 1 until reset.
- Pop after wraparound returns the most recent RAS_DEPTH addresses in LIFO order. Older addresses are lost.
- stall=1: pc, stack, count and overflow all hold, regardless of ret/br_taken. Combinational outputs still track the held state.
- Latency: selection is combinational; the new pc is visible one cycle after the controlling inputs.
- No X propagation: unused offset fields are ignored under the current branch_type.

Test Plan:
1. Reset, then 4 idle cycles -> pc 0x0000,0x0001,0x0002,0x0003,0x0004; link_pc = pc+1; ras_empty=1. Free-run from pc=0xFFFF -> next pc 0x0000.
2. pc=0x0010, br_taken, type 00, cond_offset=0xF8 -> pc 0x0008. Then type 01, uncond_offset=0x100 -> pc 0x0108. Then reg_branch=1, reg_target=0xBEEF -> pc 0xBEEF.
3. pc=0x0020, br_taken, type 10, link_offset=0x05 -> pc 0x0025, ras_top 0x0021, ras_count 1. Then ret -> pc 0x0021, ras_empty=1.
4. RAS_DEPTH=4: 5 nested calls from pcs A..E -> ras_full=1, ras_overflow=1, count 4.
   - 4 rets -> pc E+1, D+1, C+1, B+1.
   - 5th ret with reg_target=0x1234 -> pc 0x1234, count 0.
5. ret and br_taken (type 10) in the same cycle with RAS non-empty -> pc=ras_top, pop only, no push. stall=1 with ret or a call -> pc, ras_count and ras_top unchanged for every stalled cycle.
6. Reset asserted in the same cycle as a call, with count=3 and overflow=1 -> next cycle pc=RESET_PC, count 0, overflow 0, ras_top 0.
